// File: rtl/smctl_pipe.sv
// smctl_pipe: two-stage pipelined shift/mask unit for byte-field operations.
//
// Stage 1 decodes op/pos/len into a left-rotate amount and the right/left
// mask bounds, and captures the operands. Stage 2 builds the field mask,
// rotates the source word and merges it with the merge word. Both stages
// use a valid/ready handshake, so up to two items can be in flight.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready
//   in_op      0=ROT, 1=LDB, 2=DPB, 3=SELDEP
//   in_pos     byte position / rotate count
//   in_len     field width minus 1
//   in_a       source word (rotated operand)
//   in_b       merge word (DPB/SELDEP)
//   out_valid  result valid
//   out_ready  consumer accepts when out_valid & out_ready
//   out_data   result word
//   out_mask   field mask used to produce out_data
module smctl_pipe #(
    parameter int W  = 32,
    parameter int LW = $clog2(W)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [LW-1:0] in_pos,
    input  logic [LW-1:0] in_len,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [W-1:0]  out_mask
);

    typedef enum logic [1:0] {
        OP_ROT    = 2'd0,
        OP_LDB    = 2'd1,
        OP_DPB    = 2'd2,
        OP_SELDEP = 2'd3
    } op_e;

    // Stage-1 state
    logic          s1_valid;
    op_e           s1_op;
    logic [LW-1:0] s1_rot;
    logic [LW-1:0] s1_mskr;
    logic [LW-1:0] s1_mskl;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;

    logic          s1_advance;
    logic          accept;

    // Stage 1 may hand its item on whenever the output register is empty
    // or is being drained this cycle; in_ready never looks at in_valid.
    assign s1_advance = ~out_valid | out_ready;
    assign in_ready   = ~s1_valid | s1_advance;
    assign accept     = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Stage 1 decode
    // ------------------------------------------------------------------
    op_e           dec_op;
    logic [LW-1:0] dec_rot;
    logic [LW-1:0] dec_mskr;
    logic [LW-1:0] dec_mskl;

    assign dec_op = op_e'(in_op);

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_rot  = '0;
        dec_mskr = in_pos;
        case (dec_op)
            OP_ROT, OP_DPB: dec_rot = in_pos;
            // Right rotate by pos == left rotate by (W - pos) mod W; W is 2^LW
            // so the LW-bit negate gives exactly that.
            OP_LDB: begin
                dec_rot  = LW'(0) - in_pos;
                dec_mskr = '0;
            end
            default: dec_rot = '0;
        endcase
        // LW-bit add: the carry is dropped, so the left bound can wrap.
        dec_mskl = dec_mskr + in_len;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ROT;
            s1_rot   <= '0;
            s1_mskr  <= '0;
            s1_mskl  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= dec_op;
            s1_rot   <= dec_rot;
            s1_mskr  <= dec_mskr;
            s1_mskl  <= dec_mskl;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath
    // ------------------------------------------------------------------
    logic [2*W-1:0] rot_wide;
    logic [W-1:0]   rot_word;
    logic [W-1:0]   mask;
    logic [W-1:0]   result;

    // The upper half of the doubled word shifted left is a left rotate,
    // and a zero amount falls out naturally.
    assign rot_wide = {s1_a, s1_a} << s1_rot;
    assign rot_word = rot_wide[2*W-1:W];

    always_comb begin
        mask   = '0;
        result = rot_word;
        if (s1_op == OP_ROT) begin
            mask = '1;
        end else if (s1_mskl >= s1_mskr) begin
            // Bits mskr..mskl inclusive; a wrapped range leaves mask at 0.
            mask = ({W{1'b1}} << s1_mskr) & ({W{1'b1}} >> (LW'(W - 1) - s1_mskl));
        end
        case (s1_op)
            OP_ROT:            result = rot_word;
            OP_LDB:            result = rot_word & mask;
            OP_DPB, OP_SELDEP: result = (rot_word & mask) | (s1_b & ~mask);
            default:           result = rot_word;
        endcase
    end

    // The output register holds its contents while the consumer stalls, and
    // only reloads data when a real item arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_mask  <= '0;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= result;
                out_mask <= mask;
            end
        end
    end

endmodule
